// File: rtl/nco_hop_sched.sv
// Frequency-hop / sweep scheduler for the streaming NCO: steps a table of
// {phase increment, dwell} entries at the sample rate and tags NCO output with its hop index.
module nco_hop_sched #(
  parameter int unsigned APR      = 32,
  parameter int unsigned NHOP     = 8,
  parameter int unsigned LOG2NHOP = 3,
  parameter int unsigned DWW      = 16,
  parameter int unsigned LAT      = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cfg_we,
  input  logic [LOG2NHOP-1:0] cfg_addr,
  input  logic [APR-1:0]      cfg_inc,
  input  logic [DWW-1:0]      cfg_dwell,
  input  logic [LOG2NHOP-1:0] cfg_last,
  input  logic                mode_loop,
  input  logic                start,
  input  logic                stop,
  input  logic                sample_en,
  output logic [APR-1:0]      phi_inc_o,
  output logic                clken_o,
  output logic [LOG2NHOP-1:0] hop_idx_o,
  output logic                busy,
  output logic                done
);

  localparam int unsigned DCW = $clog2(LAT + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_DRAIN = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [LOG2NHOP-1:0] idx_q, idx_d;
  logic [LOG2NHOP-1:0] last_q, last_d;
  logic                loop_q, loop_d;
  logic [APR-1:0]      phi_q, phi_d;
  logic [DWW-1:0]      dwell_cnt_q, dwell_cnt_d;
  logic [DCW-1:0]      drain_cnt_q, drain_cnt_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic [APR-1:0]      inc_q   [NHOP];
  logic [DWW-1:0]      dwell_q [NHOP];
  logic [LOG2NHOP-1:0] line_q  [LAT];

  logic [LOG2NHOP-1:0] nxt_idx_c;

  // A programmed dwell of zero still issues one sample.
  function automatic logic [DWW-1:0] dwell_sat(input logic [DWW-1:0] d);
    return (d == '0) ? DWW'(1) : d;
  endfunction

  assign clken_o   = ((state_q == S_RUN) || (state_q == S_DRAIN)) && sample_en;
  assign nxt_idx_c = (idx_q < last_q) ? (idx_q + LOG2NHOP'(1)) : '0;

  assign phi_inc_o = phi_q;
  assign hop_idx_o = line_q[LAT-1];
  assign busy      = busy_q;
  assign done      = done_q;

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    last_d      = last_q;
    loop_d      = loop_q;
    phi_d       = phi_q;
    dwell_cnt_d = dwell_cnt_q;
    drain_cnt_d = drain_cnt_q;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d     = S_LOAD;
          idx_d       = '0;
          last_d      = cfg_last;
          loop_d      = mode_loop;
          drain_cnt_d = '0;
        end
      end
      S_LOAD: begin
        phi_d       = inc_q[idx_q];
        dwell_cnt_d = dwell_sat(dwell_q[idx_q]);
        state_d     = S_RUN;
      end
      S_RUN: begin
        if (stop) begin
          state_d     = S_DRAIN;
          drain_cnt_d = '0;
        end else if (clken_o) begin
          if (dwell_cnt_q > DWW'(1)) begin
            dwell_cnt_d = dwell_cnt_q - DWW'(1);
          end else if ((idx_q < last_q) || loop_q) begin
            // Next hop loads on the same edge so there is no gap in the sample stream.
            idx_d       = nxt_idx_c;
            phi_d       = inc_q[nxt_idx_c];
            dwell_cnt_d = dwell_sat(dwell_q[nxt_idx_c]);
          end else begin
            state_d     = S_DRAIN;
            drain_cnt_d = '0;
          end
        end
      end
      S_DRAIN: begin
        if (clken_o) begin
          if (drain_cnt_q == DCW'(LAT - 1)) begin
            state_d = S_IDLE;
          end else begin
            drain_cnt_d = drain_cnt_q + DCW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
    done_d = (state_q == S_DRAIN) && (state_d == S_IDLE);
  end

  // Control and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      idx_q       <= '0;
      last_q      <= '0;
      loop_q      <= 1'b0;
      phi_q       <= '0;
      dwell_cnt_q <= '0;
      drain_cnt_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      last_q      <= last_d;
      loop_q      <= loop_d;
      phi_q       <= phi_d;
      dwell_cnt_q <= dwell_cnt_d;
      drain_cnt_q <= drain_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  // Hop table; reads above see the pre-write contents on a same-cycle write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NHOP); i++) begin
        inc_q[i]   <= '0;
        dwell_q[i] <= '0;
      end
    end else if (cfg_we) begin
      for (int i = 0; i < int'(NHOP); i++) begin
        if (cfg_addr == LOG2NHOP'(i)) begin
          inc_q[i]   <= cfg_inc;
          dwell_q[i] <= cfg_dwell;
        end
      end
    end
  end

  // Index line advances with the NCO so the tail matches its output sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(LAT); i++) begin
        line_q[i] <= '0;
      end
    end else if (clken_o) begin
      line_q[0] <= idx_q;
      for (int i = 1; i < int'(LAT); i++) begin
        line_q[i] <= line_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_nco_hop_sched.sv
// Directed bench for nco_hop_sched: idle, single pass, throttled loop with
// live table write, async reset, zero dwell, stop and start/stop collision.
module tb_nco_hop_sched;

  logic        clk;
  logic        reset_n;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [31:0] cfg_inc;
  logic [15:0] cfg_dwell;
  logic [2:0]  cfg_last;
  logic        mode_loop;
  logic        start;
  logic        stop;
  logic        sample_en;
  logic [31:0] phi_inc_o;
  logic        clken_o;
  logic [2:0]  hop_idx_o;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  nco_hop_sched #(
    .APR(32), .NHOP(8), .LOG2NHOP(3), .DWW(16), .LAT(10)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_inc(cfg_inc), .cfg_dwell(cfg_dwell),
    .cfg_last(cfg_last), .mode_loop(mode_loop), .start(start), .stop(stop),
    .sample_en(sample_en), .phi_inc_o(phi_inc_o), .clken_o(clken_o),
    .hop_idx_o(hop_idx_o), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] inc, input logic [15:0] dw);
    @(negedge clk);
    cfg_we = 1'b1; cfg_addr = a; cfg_inc = inc; cfg_dwell = dw;
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  // Expected increment for enabled-sample count k in the looping run.
  function automatic logic [31:0] loop_inc(input int k);
    int h;
    h = k % 6;
    if (h < 3) return 32'h0100_0000;
    if (h < 5) return (k >= 6) ? 32'h0800_0000 : 32'h0200_0000;
    return 32'h0400_0000;
  endfunction

  function automatic logic [2:0] loop_idx(input int k);
    int h;
    h = k % 6;
    if (h < 3) return 3'd0;
    if (h < 5) return 3'd1;
    return 3'd2;
  endfunction

  logic [31:0] seq_inc [16];
  logic [2:0]  seq_idx [16];

  initial begin
    reset_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_inc = '0; cfg_dwell = '0;
    cfg_last = '0; mode_loop = 1'b0; start = 1'b0; stop = 1'b0; sample_en = 1'b1;

    // Reset state
    @(negedge clk); @(negedge clk); #1;
    check("rst_phi", phi_inc_o, 0);
    check("rst_clken", clken_o, 0);
    check("rst_hop_idx", hop_idx_o, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    reset_n = 1'b1;

    // Idle with sample_en high
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      check("idle_clken", clken_o, 0);
      check("idle_phi", phi_inc_o, 0);
    end

    // Single pass
    wr(3'd0, 32'h0100_0000, 16'd3);
    wr(3'd1, 32'h0200_0000, 16'd2);
    wr(3'd2, 32'h0400_0000, 16'd1);
    for (int i = 0; i < 3; i++)  begin seq_inc[i] = 32'h0100_0000; seq_idx[i] = 3'd0; end
    for (int i = 3; i < 5; i++)  begin seq_inc[i] = 32'h0200_0000; seq_idx[i] = 3'd1; end
    for (int i = 5; i < 16; i++) begin seq_inc[i] = 32'h0400_0000; seq_idx[i] = 3'd2; end
    @(negedge clk);
    cfg_last = 3'd2; mode_loop = 1'b0; sample_en = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    check("sp_load_clken", clken_o, 0);
    check("sp_load_busy", busy, 1);
    for (int j = 0; j < 16; j++) begin
      @(negedge clk); #1;
      check("sp_clken", clken_o, 1);
      check("sp_phi", phi_inc_o, seq_inc[j]);
      check("sp_busy", busy, 1);
      check("sp_done", done, 0);
      check("sp_hop_idx", hop_idx_o, (j >= 10) ? seq_idx[j-10] : 3'd0);
    end
    @(negedge clk); #1;
    check("sp_end_done", done, 1);
    check("sp_end_busy", busy, 0);
    check("sp_end_clken", clken_o, 0);
    check("sp_end_phi", phi_inc_o, 32'h0400_0000);
    check("sp_end_hop_idx", hop_idx_o, 2);
    @(negedge clk); #1;
    check("sp_done_pulse", done, 0);

    // Looping, strobe every 4th cycle, entry 1 rewritten during hop 1
    sample_en = 1'b0; cfg_last = 3'd2; mode_loop = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    check("lp_load_busy", busy, 1);
    for (int c = 0; c < 72; c++) begin
      int s;
      @(negedge clk);
      sample_en = ((c % 4) == 0);
      if (c == 10) begin
        cfg_we = 1'b1; cfg_addr = 3'd1; cfg_inc = 32'h0800_0000; cfg_dwell = 16'd2;
      end else begin
        cfg_we = 1'b0;
      end
      #1;
      s = (c + 3) / 4;
      check("lp_clken", clken_o, ((c % 4) == 0));
      check("lp_phi", phi_inc_o, loop_inc(s));
      check("lp_hop_idx", hop_idx_o, (s < 10) ? 3'd2 : loop_idx(s - 10));
    end

    // Async reset in the middle of RUN
    @(negedge clk);
    sample_en = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    check("arst_phi", phi_inc_o, 0);
    check("arst_clken", clken_o, 0);
    check("arst_hop_idx", hop_idx_o, 0);
    check("arst_busy", busy, 0);
    check("arst_done", done, 0);
    @(negedge clk);
    reset_n = 1'b1;

    // Zero dwell on entry 0, then stop during entry 1
    wr(3'd0, 32'h0100_0000, 16'd0);
    wr(3'd1, 32'h0200_0000, 16'd5);
    wr(3'd2, 32'h0400_0000, 16'd1);
    @(negedge clk);
    cfg_last = 3'd2; mode_loop = 1'b0; sample_en = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0; #1;
    check("st_load_busy", busy, 1);
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      if (j == 2) stop = 1'b1;
      if (j == 5) start = 1'b1;
      #1;
      check("st_hop_idx", hop_idx_o, (j <= 10) ? 3'd0 : 3'd1);
      if (j == 0) begin
        check("st_dwell0_phi", phi_inc_o, 32'h0100_0000);
        check("st_clken", clken_o, 1);
      end else if (j <= 12) begin
        check("st_phi", phi_inc_o, 32'h0200_0000);
        check("st_clken", clken_o, 1);
        check("st_busy", busy, 1);
      end else if (j == 13) begin
        check("st_done", done, 1);
        check("st_busy_end", busy, 0);
        check("st_clken_end", clken_o, 0);
        check("st_phi_hold", phi_inc_o, 32'h0200_0000);
      end else begin
        check("st_collide_busy", busy, 0);
        check("st_collide_done", done, 0);
        check("st_collide_clken", clken_o, 0);
      end
    end
    start = 1'b0; stop = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
